// File: rtl/frame_cfg_pkg.sv
// Shared constants, header field layout and FSM state encoding for the
// column configuration frame writer.
package frame_cfg_pkg;

  localparam int          WORD_W     = 32;
  localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;
  localparam int          DESYNC_BIT = 31;
  localparam int          COL_LSB    = 8;
  localparam int          FRAME_LSB  = 0;
  localparam int          FIELD_W    = 8;
  localparam int          COUNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame to one-hot frame strobe decode; the writer
// registers the result so the strobe leaves the block glitch-free.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int NumColumns      = 23,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [FIELD_W-1:0]                    column_i,
  input  logic [FIELD_W-1:0]                    frame_i,
  input  logic                                  enable_i,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

  always_comb begin
    // NOTE: default every bit before the loops so no path leaves strobe_o
    // unassigned, which would otherwise infer a latch.
    strobe_o = '0;
    if (enable_i) begin
      for (int c = 0; c < NumColumns; c++) begin
        for (int f = 0; f < MaxFramesPerCol; f++) begin
          if ((column_i == FIELD_W'(c)) && (frame_i == FIELD_W'(f))) begin
            strobe_o[c*MaxFramesPerCol + f] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Parses a sync/header/data word stream and writes configuration frames to
// the tile array: stable FrameData, then a single-cycle one-hot FrameStrobe.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int NumRows         = 7,
  parameter int NumColumns      = 23,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [WORD_W-1:0]                     WriteData,
  input  logic                                  WriteValid,
  output logic                                  WriteReady,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  ConfigDone,
  output logic                                  ErrorFlag,
  output logic [COUNT_W-1:0]                    FramesWritten
);

  if (FrameBitsPerRow != WORD_W) begin : g_bad_row_width
    $error("frame_config_writer: FrameBitsPerRow must equal the 32-bit word width");
  end
  if (NumColumns > (1 << FIELD_W) || MaxFramesPerCol > (1 << FIELD_W)) begin : g_bad_field
    $error("frame_config_writer: column/frame count exceeds 8-bit header field");
  end

  localparam int                 RowW      = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0]    LastRow   = RowW'(NumRows - 1);
  localparam logic [FIELD_W-1:0] ColLimit  = FIELD_W'(NumColumns);
  localparam logic [FIELD_W-1:0] FrameLimit = FIELD_W'(MaxFramesPerCol);
  localparam int                 StrobeW   = NumColumns * MaxFramesPerCol;

  state_e                          state_q;
  logic [RowW-1:0]                 row_q;
  logic [FIELD_W-1:0]              col_q;
  logic [FIELD_W-1:0]              frame_q;
  logic [NumRows*WORD_W-1:0]       frame_data_q;
  logic [StrobeW-1:0]              strobe_q;
  logic                            config_done_q;
  logic                            error_q;
  logic [COUNT_W-1:0]              frames_written_q;
  logic [COUNT_W-1:0]              frames_written_d;

  logic                            accept;
  logic [FIELD_W-1:0]              hdr_col;
  logic [FIELD_W-1:0]              hdr_frame;
  logic                            hdr_bad;
  logic [StrobeW-1:0]              strobe_d;

  // Ready is gated by resetn directly so the source sees it drop the same cycle.
  assign WriteReady = resetn & (state_q inside {IDLE, HEADER, DATA});
  assign accept     = WriteValid & WriteReady;

  assign hdr_col    = WriteData[COL_LSB +: FIELD_W];
  assign hdr_frame  = WriteData[FRAME_LSB +: FIELD_W];
  assign hdr_bad    = (hdr_col >= ColLimit) || (hdr_frame >= FrameLimit);

  assign frames_written_d = sat_inc(frames_written_q);

  frame_strobe_decoder #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_decoder (
    .column_i (col_q),
    .frame_i  (frame_q),
    .enable_i (state_q == SETUP),
    .strobe_o (strobe_d)
  );

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      // NOTE: FrameData is a plain register bank, not a RAM, so it is reset
      // with the control state; a reset mid-frame must leave it cleared.
      state_q          <= IDLE;
      row_q            <= '0;
      col_q            <= '0;
      frame_q          <= '0;
      frame_data_q     <= '0;
      strobe_q         <= '0;
      config_done_q    <= 1'b0;
      error_q          <= 1'b0;
      frames_written_q <= '0;
    end else begin
      strobe_q      <= '0;
      config_done_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept && (WriteData == SYNC_WORD)) begin
            state_q          <= HEADER;
            error_q          <= 1'b0;
            frames_written_q <= '0;
          end
        end

        HEADER: begin
          if (accept) begin
            if (WriteData[DESYNC_BIT]) begin
              state_q       <= IDLE;
              config_done_q <= 1'b1;
            end else if (hdr_bad) begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end else begin
              col_q   <= hdr_col;
              frame_q <= hdr_frame;
              row_q   <= '0;
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            for (int r = 0; r < NumRows; r++) begin
              if (row_q == RowW'(r)) begin
                frame_data_q[r*WORD_W +: WORD_W] <= WriteData;
              end
            end
            if (row_q == LastRow) begin
              state_q <= SETUP;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end

        SETUP: begin
          state_q          <= STROBE;
          strobe_q         <= strobe_d;
          frames_written_q <= frames_written_d;
        end

        STROBE:  state_q <= HOLD;
        HOLD:    state_q <= HEADER;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FrameData     = frame_data_q;
  assign FrameStrobe   = strobe_q;
  assign ConfigDone    = config_done_q;
  assign ErrorFlag     = error_q;
  assign FramesWritten = frames_written_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed and randomised-gap bench for frame_config_writer; a scoreboard
// queue holds the expected strobe index, frame data and strobe cycle.
module tb_frame_config_writer;

  localparam int NR = 2;
  localparam int NC = 3;
  localparam int MF = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic             CLK = 1'b0;
  logic             resetn = 1'b0;
  logic [31:0]      WriteData = '0;
  logic             WriteValid = 1'b0;
  logic             WriteReady;
  logic [NR*32-1:0] FrameData;
  logic [NC*MF-1:0] FrameStrobe;
  logic             ConfigDone;
  logic             ErrorFlag;
  logic [15:0]      FramesWritten;

  frame_config_writer #(
    .NumRows         (NR),
    .NumColumns      (NC),
    .MaxFramesPerCol (MF),
    .FrameBitsPerRow (32)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .WriteData     (WriteData),
    .WriteValid    (WriteValid),
    .WriteReady    (WriteReady),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .ConfigDone    (ConfigDone),
    .ErrorFlag     (ErrorFlag),
    .FramesWritten (FramesWritten)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          neg_cnt = 0;
  int          hs_neg = 0;
  int          last_wait = 0;
  int          hdr_wait = 0;
  logic [63:0] model_fd = '0;
  bit          prev_strobe = 1'b0;
  exp_t        mon_e;
  int          mon_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must be one-hot, single-cycle and match the queue head.
  always @(negedge CLK) begin
    neg_cnt++;
    if (FrameStrobe != '0) begin
      check("strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
      check("strobe_single_cycle", {63'b0, prev_strobe}, 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 64'(FrameStrobe), 64'd0);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_idx = -1;
        for (int i = 0; i < NC*MF; i++) if (FrameStrobe[i]) mon_idx = i;
        check("strobe_index", 64'(mon_idx), 64'(mon_e.idx));
        check("frame_data", FrameData, mon_e.data);
        check("strobe_latency", 64'(neg_cnt), 64'(mon_e.cyc));
      end
    end
    prev_strobe = |FrameStrobe;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called just after a negedge; returns at the negedge following the handshake.
  task automatic send(input logic [31:0] w);
    int waited = 0;
    WriteData  = w;
    WriteValid = 1'b1;
    while (!WriteReady && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!WriteReady) begin
      check("ready_timeout", {63'b0, WriteReady}, 64'd1);
      WriteValid = 1'b0;
      return;
    end
    @(posedge CLK);
    hs_neg    = neg_cnt;
    last_wait = waited;
    @(negedge CLK);
    WriteValid = 1'b0;
  endtask

  task automatic frame(input int col, input int fr, input logic [31:0] d0,
                       input logic [31:0] d1, input int exp_idx, input bit gaps);
    exp_t e;
    send({16'h0, 8'(col), 8'(fr)});
    hdr_wait = last_wait;
    if (gaps) idle($urandom_range(0, 1));
    send(d0);
    model_fd[31:0] = d0;
    if (gaps) idle($urandom_range(0, 1));
    send(d1);
    model_fd[63:32] = d1;
    e.idx  = exp_idx;
    e.data = model_fd;
    e.cyc  = hs_neg + 2;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int f;

    // Reset state
    idle(2);
    check("reset_ready", {63'b0, WriteReady}, 64'd0);
    check("reset_strobe", 64'(FrameStrobe), 64'd0);
    check("reset_fd", FrameData, 64'd0);
    check("reset_done", {63'b0, ConfigDone}, 64'd0);
    check("reset_err", {63'b0, ErrorFlag}, 64'd0);
    check("reset_count", 64'(FramesWritten), 64'd0);
    resetn = 1'b1;
    idle(1);
    check("ready_after_reset", {63'b0, WriteReady}, 64'd1);

    // Single frame, column 1 frame 5
    send(SYNC);
    frame(1, 5, 32'hDEADBEEF, 32'h12345678, 25, 1'b0);
    idle(4);
    check("t1_count", 64'(FramesWritten), 64'd1);
    check("t1_fd_hold", FrameData, 64'h12345678_DEADBEEF);

    // Resync (first sync in HEADER is a desync), then back-to-back frames
    send(SYNC);
    check("desync_done_pulse", {63'b0, ConfigDone}, 64'd1);
    idle(1);
    check("desync_done_clear", {63'b0, ConfigDone}, 64'd0);
    send(SYNC);
    check("sync_clears_count", 64'(FramesWritten), 64'd0);
    frame(0, 0, 32'hA5A5_0001, 32'h5A5A_0002, 0, 1'b0);
    frame(2, 19, 32'h0BAD_CAFE, 32'hFEED_F00D, 59, 1'b0);
    check("ready_low_cycles", 64'(hdr_wait), 64'd3);
    idle(4);
    check("t2_count", 64'(FramesWritten), 64'd2);

    // Bad column, trailing words discarded, sync clears the flag
    send(32'h0000_0300);
    check("err_set", {63'b0, ErrorFlag}, 64'd1);
    send(32'h1111_1111);
    send(32'h2222_2222);
    check("idle_accepts", 64'(last_wait), 64'd0);
    idle(4);
    check("err_sticky", {63'b0, ErrorFlag}, 64'd1);
    send(SYNC);
    check("err_cleared", {63'b0, ErrorFlag}, 64'd0);

    // Desync header, garbage in IDLE, desync again
    send(32'h8000_0000);
    check("done_pulse_a", {63'b0, ConfigDone}, 64'd1);
    idle(1);
    check("done_clear_a", {63'b0, ConfigDone}, 64'd0);
    send(32'h0000_0000);
    check("garbage0_accepted", 64'(last_wait), 64'd0);
    send(32'hFFFF_FFFF);
    check("garbage1_accepted", 64'(last_wait), 64'd0);
    check("garbage_no_done", {63'b0, ConfigDone}, 64'd0);
    send(SYNC);
    send(32'h8000_0000);
    check("done_pulse_b", {63'b0, ConfigDone}, 64'd1);
    idle(1);
    check("done_clear_b", {63'b0, ConfigDone}, 64'd0);

    // Reset after first data word of a frame
    send(SYNC);
    send(32'h0000_0105);
    send(32'hCAFE_F00D);
    check("partial_fd_written", FrameData[31:0], 64'hCAFE_F00D);
    resetn = 1'b0;
    #1;
    check("ready_in_reset_comb", {63'b0, WriteReady}, 64'd0);
    idle(1);
    check("ready_in_reset", {63'b0, WriteReady}, 64'd0);
    check("reset_mid_fd", FrameData, 64'd0);
    check("reset_mid_count", 64'(FramesWritten), 64'd0);
    resetn = 1'b1;
    model_fd = '0;
    idle(1);
    check("ready_after_release", {63'b0, WriteReady}, 64'd1);
    idle(4);

    // 100 random frames with random WriteValid gaps
    send(SYNC);
    for (int n = 0; n < 100; n++) begin
      idle($urandom_range(0, 2));
      c = $urandom_range(0, NC-1);
      f = $urandom_range(0, MF-1);
      frame(c, f, $urandom, $urandom, c*MF + f, 1'b1);
    end
    idle(6);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("rand_count", 64'(FramesWritten), 64'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
